// File: rtl/small_tensor_core.sv
// 4x4 signed matrix multiply C = A x B, one inner-product step per clock over four cycles.
// Define TENSOR_CORE_SATURATE_EN to clamp results to the element range instead of wrapping.
module small_tensor_core #(
  parameter int BUS_WIDTH = 3
) (
  input  logic                        clock_in,
  input  logic                        reset_in,
  input  logic                        tensor_core_register_file_write_enable,
  input  logic signed [BUS_WIDTH:0]   tensor_core_input1 [4][4],
  input  logic signed [BUS_WIDTH:0]   tensor_core_input2 [4][4],
  output logic signed [BUS_WIDTH:0]   tensor_core_output [4][4],
  output logic                        is_done_with_calculation
);

  localparam int EW = BUS_WIDTH + 1;
  localparam int AW = 2 * EW + 2;

`ifdef TENSOR_CORE_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_MAX = AW'((2 ** BUS_WIDTH) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-(2 ** BUS_WIDTH));
`endif

  typedef enum logic {IDLE, CALC} state_t;

  state_t                state_reg;
  logic [1:0]            k_reg;
  logic signed [AW-1:0]  acc_reg [4][4];
  logic signed [AW-1:0]  a_ext   [4][4];
  logic signed [AW-1:0]  b_ext   [4][4];
  logic signed [AW-1:0]  sum_next [4][4];
  logic signed [EW-1:0]  res_next [4][4];

  genvar gi, gj;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      for (gj = 0; gj < 4; gj++) begin : g_col
        // Operands are sign-extended first so the product is exact at accumulator width.
        assign a_ext[gi][gj]    = AW'(tensor_core_input1[gi][k_reg]);
        assign b_ext[gi][gj]    = AW'(tensor_core_input2[k_reg][gj]);
        assign sum_next[gi][gj] = acc_reg[gi][gj] + a_ext[gi][gj] * b_ext[gi][gj];
`ifdef TENSOR_CORE_SATURATE_EN
        assign res_next[gi][gj] = (sum_next[gi][gj] > SAT_MAX) ? SAT_MAX[EW-1:0] :
                                  (sum_next[gi][gj] < SAT_MIN) ? SAT_MIN[EW-1:0] :
                                  sum_next[gi][gj][EW-1:0];
`else
        assign res_next[gi][gj] = sum_next[gi][gj][EW-1:0];
`endif
      end
    end
  endgenerate

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_reg                <= IDLE;
      k_reg                    <= 2'd0;
      is_done_with_calculation <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          acc_reg[i][j]            <= '0;
          tensor_core_output[i][j] <= '0;
        end
      end
    end else begin
      is_done_with_calculation <= 1'b0;
      // A write always restarts, even in the middle of a calculation.
      if (tensor_core_register_file_write_enable) begin
        state_reg <= CALC;
        k_reg     <= 2'd0;
        for (int i = 0; i < 4; i++) begin
          for (int j = 0; j < 4; j++) begin
            acc_reg[i][j] <= '0;
          end
        end
      end else begin
        case (state_reg)
          CALC: begin
            k_reg <= k_reg + 2'd1;
            for (int i = 0; i < 4; i++) begin
              for (int j = 0; j < 4; j++) begin
                acc_reg[i][j] <= sum_next[i][j];
              end
            end
            if (k_reg == 2'd3) begin
              state_reg                <= IDLE;
              is_done_with_calculation <= 1'b1;
              for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                  tensor_core_output[i][j] <= res_next[i][j];
                end
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_small_tensor_core.sv
// Directed bench for small_tensor_core: scoreboard of expected matrices, checked on the done pulse.
module tb_small_tensor_core;
  localparam int BW = 3;
  typedef logic [63:0] mat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic we  = 1'b0;
  logic signed [BW:0] in1 [4][4];
  logic signed [BW:0] in2 [4][4];
  logic signed [BW:0] out [4][4];
  logic done;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  mat_t exp_q[$];
  mat_t last_c = '0;

  always #5 clk = ~clk;

  small_tensor_core #(.BUS_WIDTH(BW)) dut (
    .clock_in                               (clk),
    .reset_in                               (rst),
    .tensor_core_register_file_write_enable (we),
    .tensor_core_input1                     (in1),
    .tensor_core_input2                     (in2),
    .tensor_core_output                     (out),
    .is_done_with_calculation               (done)
  );

  function automatic mat_t get_out();
    mat_t m;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        m[(i*4+j)*4 +: 4] = out[i][j];
    return m;
  endfunction

  function automatic mat_t fill(int v);
    mat_t m;
    for (int i = 0; i < 16; i++) m[i*4 +: 4] = 4'(v);
    return m;
  endfunction

  function automatic mat_t identity();
    mat_t m;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        m[(i*4+j)*4 +: 4] = (i == j) ? 4'd1 : 4'd0;
    return m;
  endfunction

  function automatic mat_t diff();
    mat_t m;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        m[(i*4+j)*4 +: 4] = 4'(i - j);
    return m;
  endfunction

  function automatic mat_t model(mat_t a, mat_t b);
    mat_t m;
    logic signed [3:0] ea, eb;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        int s = 0;
        for (int k = 0; k < 4; k++) begin
          ea = a[(i*4+k)*4 +: 4];
          eb = b[(k*4+j)*4 +: 4];
          s += int'(ea) * int'(eb);
        end
`ifdef TENSOR_CORE_SATURATE_EN
        if (s > 7) s = 7;
        if (s < -8) s = -8;
`endif
        m[(i*4+j)*4 +: 4] = 4'(s);
      end
    return m;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic set_ops(mat_t a, mat_t b);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        in1[i][j] = a[(i*4+j)*4 +: 4];
        in2[i][j] = b[(i*4+j)*4 +: 4];
      end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  // Called right after the last write edge N; expects done exactly at N+4.
  task automatic wait_done(string tag);
    mat_t expv;
    for (int c = 1; c <= 3; c++) begin
      edge_step();
      check({tag, "_done_low"}, 64'(done), 64'(1'b0));
      check({tag, "_held"}, get_out(), last_c);
    end
    edge_step();
    check({tag, "_done_high"}, 64'(done), 64'(1'b1));
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 64'(1), 64'(0));
      expv = last_c;
    end else begin
      expv = exp_q.pop_front();
    end
    check({tag, "_result"}, get_out(), expv);
    last_c = expv;
    edge_step();
    check({tag, "_done_fall"}, 64'(done), 64'(1'b0));
    check({tag, "_result_kept"}, get_out(), last_c);
    $display("txn %s: C=%h done seen at N+4", tag, get_out());
  endtask

  task automatic run_txn(string tag, mat_t a, mat_t b);
    set_ops(a, b);
    we = 1'b1;
    edge_step();
    we = 1'b0;
    exp_q.push_back(model(a, b));
    wait_done(tag);
  endtask

  initial begin
    mat_t ra, rb;
    set_ops('0, '0);

    // Asynchronous reset visible before the first clock edge.
    rst = 1'b1;
    #2;
    check("reset_out", get_out(), '0);
    check("reset_done", 64'(done), 64'(1'b0));
    edge_step();
    edge_step();
    rst = 1'b0;
    edge_step();
    check("idle_no_done", 64'(done), 64'(1'b0));

    run_txn("identity", identity(), diff());
    check("identity_eq_b", last_c, diff());
    run_txn("all_ones", fill(1), fill(1));
    run_txn("all_twos", fill(2), fill(2));
    run_txn("all_m8", fill(-8), fill(-8));
    run_txn("m8_by_1", fill(-8), fill(1));
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    run_txn("random", ra, rb);

    // Idle hold: no spurious done, result stays.
    for (int c = 0; c < 3; c++) begin
      edge_step();
      check("idle_done", 64'(done), 64'(1'b0));
      check("idle_hold", get_out(), last_c);
    end

    // Restart two cycles into a calculation.
    set_ops(fill(1), fill(1));
    we = 1'b1;
    edge_step();
    we = 1'b0;
    edge_step();
    check("restart_done0", 64'(done), 64'(1'b0));
    set_ops(identity(), diff());
    we = 1'b1;
    edge_step();
    we = 1'b0;
    check("restart_done1", 64'(done), 64'(1'b0));
    check("restart_held", get_out(), last_c);
    exp_q.push_back(model(identity(), diff()));
    wait_done("restart");

    // Write enable held for three edges.
    set_ops(fill(1), fill(1));
    we = 1'b1;
    edge_step();
    edge_step();
    edge_step();
    we = 1'b0;
    exp_q.push_back(model(fill(1), fill(1)));
    wait_done("we_held");

    // Reset mid-period during a calculation.
    set_ops(identity(), diff());
    we = 1'b1;
    edge_step();
    we = 1'b0;
    edge_step();
    edge_step();
    #3;
    rst = 1'b1;
    #1;
    check("midreset_out", get_out(), '0);
    check("midreset_done", 64'(done), 64'(1'b0));
    last_c = '0;
    #2;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      edge_step();
      check("post_reset_done", 64'(done), 64'(1'b0));
      check("post_reset_out", get_out(), '0);
    end

    run_txn("recover", identity(), diff());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
